// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Purpose : shared constants and helpers for the parametrised register file.
//           Holds the default geometry of the classic MIPS register file
//           (32 x 32-bit, two read ports) and the zero-register predicate
//           used by both the storage/scoreboard logic and the read ports.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF / N_READ_DEF  default parameter values
//   DEPTH                                 register count for the default width
//   is_zero_reg()                         "address hits the hardwired zero"
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int N_READ_DEF = 2;

    // Depth of a register file built with the default address width.
    // The top module derives its own DEPTH from its actual ADDR_W.
    localparam int DEPTH = 2 ** ADDR_W_DEF;

    // True when the zero register is enabled and the address selects it.
    // Addresses are widened to 32 bits by the caller so one helper serves
    // every ADDR_W.
    function automatic logic is_zero_reg(input logic        zero_en,
                                         input logic [31:0] addr);
        return zero_en && (addr == 32'd0);
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//
// Purpose : one registered read port of the register file. Chooses between
//           the hardwired zero, the same-edge write data (bypass) and the
//           stored register value, and registers the result together with
//           the "operand is final" flag.
//
// Ports:
//   Clock          in   single clock, all updates on posedge
//   Reset_n        in   asynchronous active-low reset
//   read_addr      in   address sampled this edge
//   stored_data    in   current (pre-edge) contents of reg[read_addr]
//   pending_next   in   post-edge pending bit of read_addr
//   write_active   in   a write really commits this edge (zero reg excluded)
//   write_addr     in   write address
//   write_data     in   write data
//   read_data      out  registered read data
//   read_ready     out  registered "no write pending" flag
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              pending_next,
    input  logic              write_active,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_ready
);

    logic              reads_zero;
    logic              bypass_hit;
    logic [DATA_W-1:0] next_data;
    logic              next_ready;

    // Operand selection. The zero register wins over everything, then a
    // write landing on the same address this edge, then the stored value.
    // write_active already excludes writes aimed at the zero register, so
    // the bypass can never leak data into register 0.
    always_comb begin
        reads_zero = is_zero_reg(ZERO_REG != 0, 32'(read_addr));
        bypass_hit = write_active && (write_addr == read_addr);
        next_data  = stored_data;
        next_ready = ~pending_next;
        if (reads_zero) begin
            next_data  = '0;
            next_ready = 1'b1;
        end else if (bypass_hit) begin
            next_data  = write_data;
        end
    end

    // Output flops: one cycle of latency, held stable until the next edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            read_data  <= '0;
            read_ready <= 1'b0;
        end else begin
            read_data  <= next_data;
            read_ready <= next_ready;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
//
// Purpose : parametrised multi-read-port register file with one write port,
//           an optional hardwired zero register and a pending-write
//           scoreboard. A producer "locks" its destination register when it
//           issues; the write of its result clears the lock. Each read port
//           reports whether the operand it returned is final.
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   N_READ    number of read ports (>= 1)
//   ZERO_REG  1: register 0 reads 0 and ignores writes and locks
//
// Ports:
//   Clock           in   single clock
//   Reset_n         in   asynchronous active-low reset
//   Read_Register   in   N_READ packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   Read_Data       out  N_READ packed read data, port i at [i*DATA_W +: DATA_W]
//   Read_Ready      out  per port: 1 = Read_Data holds the final value
//   Write_Enable    in   commit Write_Data to Write_Register
//   Write_Register  in   write address
//   Write_Data      in   write data
//   Lock_Enable     in   mark Lock_Register as pending
//   Lock_Register   in   register to lock
//   Lock_Error      out  one-cycle pulse: lock on an already pending register
// ---------------------------------------------------------------------------
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_READ   = N_READ_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [N_READ*ADDR_W-1:0] Read_Register,
    output logic [N_READ*DATA_W-1:0] Read_Data,
    output logic [N_READ-1:0]        Read_Ready,
    input  logic                     Write_Enable,
    input  logic [ADDR_W-1:0]        Write_Register,
    input  logic [DATA_W-1:0]        Write_Data,
    input  logic                     Lock_Enable,
    input  logic [ADDR_W-1:0]        Lock_Register,
    output logic                     Lock_Error
);

    localparam int DEPTH_R = 2 ** ADDR_W;

    logic [DATA_W-1:0]  regs [DEPTH_R];
    logic [DEPTH_R-1:0] pending;
    logic [DEPTH_R-1:0] pending_next;
    logic               write_active;
    logic               lock_active;
    logic               lock_error_next;

    // Writes and locks aimed at the hardwired zero register are dropped
    // here, so nothing downstream has to special-case them again.
    always_comb begin
        write_active = Write_Enable && !is_zero_reg(ZERO_REG != 0, 32'(Write_Register));
        lock_active  = Lock_Enable  && !is_zero_reg(ZERO_REG != 0, 32'(Lock_Register));
    end

    // Post-edge scoreboard. The lock is applied after the write clear so a
    // write and a lock to the same register leave it pending: the newly
    // issued producer owns the register. The read ports use this vector
    // directly so their ready flag already reflects this edge's activity.
    always_comb begin
        pending_next = pending;
        if (write_active) begin
            pending_next[Write_Register] = 1'b0;
        end
        if (lock_active) begin
            pending_next[Lock_Register] = 1'b1;
        end
    end

    // A second lock is an error only if the register stays pending from an
    // older producer; a same-edge write retiring that producer makes the
    // new lock legitimate.
    always_comb begin
        lock_error_next = lock_active && pending[Lock_Register] &&
                          !(write_active && (Write_Register == Lock_Register));
    end

    // Register storage.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < DEPTH_R; r++) begin
                regs[r] <= '0;
            end
        end else if (write_active) begin
            regs[Write_Register] <= Write_Data;
        end
    end

    // Pending-write scoreboard and the lock error pulse.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pending    <= '0;
            Lock_Error <= 1'b0;
        end else begin
            pending    <= pending_next;
            Lock_Error <= lock_error_next;
        end
    end

    // One read port per requested operand; each sees the stored value and
    // the post-edge pending bit of its own address.
    for (genvar p = 0; p < N_READ; p++) begin : g_read
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_stored;
        logic              port_pending;

        assign port_addr    = Read_Register[p*ADDR_W +: ADDR_W];
        assign port_stored  = regs[port_addr];
        assign port_pending = pending_next[port_addr];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .Clock        (Clock),
            .Reset_n      (Reset_n),
            .read_addr    (port_addr),
            .stored_data  (port_stored),
            .pending_next (port_pending),
            .write_active (write_active),
            .write_addr   (Write_Register),
            .write_data   (Write_Data),
            .read_data    (Read_Data[p*DATA_W +: DATA_W]),
            .read_ready   (Read_Ready[p])
        );
    end

endmodule : register_file_param
